// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and helpers for the multi-digit BCD counter.
//   DIGIT_W     : bits per BCD digit
//   DIGIT_MAX   : largest legal BCD digit (9)
//   DIGIT_MIN   : smallest BCD digit (0)
//   digit_valid : 1 when a 4-bit value is a legal BCD digit
// ----------------------------------------------------------------------------
package bcd_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;
    localparam logic [3:0]  DIGIT_MIN = 4'd0;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] v);
        return (v <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One BCD digit register with load and single-step up/down.
// Ports:
//   clk    : clock, rising edge
//   clr    : asynchronous active-low clear
//   load   : load d (illegal digit values load as 0); overrides step
//   d      : load value
//   step   : advance the digit by one in the direction given by up
//   up     : 1 = increment (9 -> 0), 0 = decrement (0 -> 9)
//   q      : current digit, always a legal BCD value
//   is_max : q == 9
//   is_min : q == 0
// ----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               is_max,
    output logic               is_min
);

    logic [DIGIT_W-1:0] q_reg;
    logic [DIGIT_W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (load) begin
            // Sanitising here keeps the register in BCD no matter what d holds
            q_next = digit_valid(d) ? d : DIGIT_MIN;
        end else if (step) begin
            if (up) begin
                q_next = (q_reg == DIGIT_MAX) ? DIGIT_MIN : q_reg + 4'd1;
            end else begin
                q_next = (q_reg == DIGIT_MIN) ? DIGIT_MAX : q_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_reg <= DIGIT_MIN;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q      = q_reg;
    assign is_max = (q_reg == DIGIT_MAX);
    assign is_min = (q_reg == DIGIT_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// ----------------------------------------------------------------------------
// bcd_counter_n
// NDIG-digit synchronous BCD up/down counter with parallel load.
// Every digit steps on the same edge; the step enable for digit k is an
// AND-prefix over the lower digits' is_max (up) or is_min (down) flags, so
// there is no ripple between digit registers.
//
// Build option: define BCD_COUNTER_SAT_EN to saturate at 9..9 / 0..0 instead
// of wrapping; wrap then pulses when a count request was blocked at the limit.
//
// Ports:
//   clk    : clock, rising edge
//   clr    : asynchronous active-low clear of all state
//   en     : count enable
//   load   : parallel load of d, priority over en
//   up     : 1 = count up, 0 = count down
//   d      : load value, digit k at d[4k+3:4k]
//   q      : current count, same layout as d
//   co     : combinational terminal count (en & ~load & at limit for up)
//   wrap   : registered pulse, previous edge wrapped (or was blocked when
//            saturating)
//   ld_err : registered pulse, previous load had a digit above 9
// ----------------------------------------------------------------------------
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
)
(
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    load,
    input  logic                    up,
    input  logic [DIGIT_W*NDIG-1:0] d,
    output logic [DIGIT_W*NDIG-1:0] q,
    output logic                    co,
    output logic                    wrap,
    output logic                    ld_err
);

    logic [NDIG-1:0] dig_max;
    logic [NDIG-1:0] dig_min;
    logic [NDIG-1:0] dig_step;
    logic [NDIG-1:0] dig_bad;

    // max_chain[k] / min_chain[k]: every digit below k is 9 / 0
    logic [NDIG:0]   max_chain;
    logic [NDIG:0]   min_chain;

    logic            count_req;
    logic            at_limit;
    logic            step_en;
    logic            wrap_reg;
    logic            wrap_next;
    logic            ld_err_reg;
    logic            ld_err_next;

    assign max_chain[0] = 1'b1;
    assign min_chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign max_chain[gi+1] = max_chain[gi] & dig_max[gi];
            assign min_chain[gi+1] = min_chain[gi] & dig_min[gi];

            assign dig_step[gi] = step_en & (up ? max_chain[gi] : min_chain[gi]);
            assign dig_bad[gi]  = ~digit_valid(d[gi*DIGIT_W +: DIGIT_W]);

            bcd_digit u_digit (
                .clk    (clk),
                .clr    (clr),
                .load   (load),
                .d      (d[gi*DIGIT_W +: DIGIT_W]),
                .step   (dig_step[gi]),
                .up     (up),
                .q      (q[gi*DIGIT_W +: DIGIT_W]),
                .is_max (dig_max[gi]),
                .is_min (dig_min[gi])
            );
        end
    endgenerate

    assign count_req = en & ~load;
    assign at_limit  = up ? max_chain[NDIG] : min_chain[NDIG];
    assign co        = count_req & at_limit;

`ifdef BCD_COUNTER_SAT_EN
    // At the limit the request is swallowed; q holds
    assign step_en = count_req & ~at_limit;
`else
    // At the limit every digit steps together, giving the modulo wrap
    assign step_en = count_req;
`endif

    // In both builds the wrap pulse marks a count request made at the limit
    assign wrap_next   = co;
    assign ld_err_next = load & (|dig_bad);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wrap_reg   <= 1'b0;
            ld_err_reg <= 1'b0;
        end else begin
            wrap_reg   <= wrap_next;
            ld_err_reg <= ld_err_next;
        end
    end

    assign wrap   = wrap_reg;
    assign ld_err = ld_err_reg;

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised N-digit synchronous BCD up/down counter built from cascaded single-digit stages with ripple-free internal carry lookahead. Supports parallel load, count enable, direction select, a terminal-count carry output for cascading further counters, and a registered wrap pulse. It is the multi-digit successor to the single-digit BCD counter and feeds display and timer logic.

Parameters:
NDIG, 4, number of BCD digits (1..8); data width is 4*NDIG.

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  asynchronous active-low reset; clr=0 clears all state immediately
en  in  1  count enable
load  in  1  synchronous parallel load; priority over en
up  in  1  direction: 1=increment, 0=decrement
d  in  4*NDIG  load value, digit k at d[4k+3:4k], digit 0 least significant
q  out  4*NDIG  current count, BCD, same digit layout as d
co  out  1  combinational terminal count for cascading
wrap  out  1  registered one-cycle pulse: previous edge wrapped the count
ld_err  out  1  registered one-cycle pulse: previous load contained a digit >9

Behaviour:
- Reset (clr=0, asynchronous): q=0, wrap=0, ld_err=0. Release is synchronous to clk.
- Priority each rising edge: load, then en, then hold.
- load=1: q<=d with each digit >9 replaced by 0; ld_err<=1 if any digit >9, else 0; wrap<=0. up and en are ignored.
- load=0, en=1, up=1: digit 0 increments. Digit k increments only when all lower digits are 9. A digit at 9 that increments becomes 0.
- load=0, en=1, up=0: digit 0 decrements. Digit k decrements only when all lower digits are 0. A digit at 0 that decrements becomes 9.
- Full wrap: all digits 9 going up, or all 0 going down, sets q to all 0 / all 9 and wrap<=1. Otherwise wrap<=0.
- load=0, en=0: q holds; wrap<=0, ld_err<=0.
- co = en & ~load & (up ? all digits ==9 : all digits ==0). Purely combinational; tracks up and en in the same cycle.
- Latency: q updates one clock after the qualifying edge. co has zero latency. wrap and ld_err are valid in the cycle after the event.
- Internally q never holds a non-BCD digit.
- Reset mid-count: state clears immediately. The first edge after release acts on zero.
- Direction change between edges: takes effect on the next edge with no glitch state.

Optional Feature:
- Macro BCD_COUNTER_SAT_EN.
- Defined: no wrap. At all 9 with up=1, or all 0 with up=0, q holds. wrap is then redefined as a one-cycle pulse meaning "saturated and count request blocked". co is unchanged.
- Undefined: modulo-10^NDIG wrap as described above.

Decomposition:
- Package bcd_pkg: DIGIT_W=4, DIGIT_MAX=4'd9, DIGIT_MIN=4'd0, and a function that checks digit validity.
- Sub-module bcd_digit: one 4-bit digit register.
  - Inputs: clk, clr, load, d, step, up.
  - Outputs: q, is_max, is_min.
- The top level generates NDIG instances. Step enables come from AND-prefix chains over the lower digits' is_max/is_min, plus wrap/ld_err/co logic.

Test Plan:
- Reset then count (NDIG=4): clr=0 -> q=0000 async. Release, en=1 up=1 for 12 edges -> q=0012, wrap=0, co=0.
- Multi-digit carry: load d=0x0999, then en=1 up=1 for one edge -> q=0x1000. Load 0x1000, up=0, one edge -> q=0x0999.
- Full wrap up and down:
  - Load 0x9999, co=1 with en=1 up=1; one edge -> q=0x0000 and wrap=1 for exactly one cycle.
  - From 0x0000 with up=0, one edge -> q=0x9999, wrap=1.
  - With BCD_COUNTER_SAT_EN defined: q holds at 0x9999 / 0x0000.
- Invalid load: d=0x3A5F, load=1 -> q=0x3050, ld_err=1 next cycle, then 0.
- Priority and hold:
  - load=1 with en=1 up=1 and d=0x0042 -> q=0x0042, no increment.
  - en=0 for 5 edges -> q stays 0x0042 and co=0 throughout.
- Async reset mid-count: assert clr=0 between edges while q=0x0567 -> q=0 before the next edge. Release, up=0 en=1 -> q=0x9999, wrap=1.
